// File: rtl/add_serial_sched_if.sv
// Requester-side bundle for the serial adder scheduler:
// per-port request handshake plus the shared result strobe.
interface add_serial_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_sum;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_sum
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_sum
  );
endinterface

// File: rtl/add_serial_sched.sv
// Round-robin scheduler sharing one bit-serial adder
// among NREQ requesters; one operation at a time.
module add_serial_sched #(
  parameter int NREQ       = 4,
  parameter int RUN_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  add_serial_sched_if.slave bus,
  output logic              busy,
  output logic              add_en,
  output logic [7:0]        add_a,
  output logic [7:0]        add_b,
  input  logic [7:0]        add_out
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(RUN_CYCLES + 1);

  typedef enum logic [2:0] {
    ARB, START, RUN, CAPT, RESP
  } state_t;

  state_t          state;
  logic [IW-1:0]   last_gnt;
  logic [IW-1:0]   gnt;
  logic [IW-1:0]   win;
  logic [IW-1:0]   cand;
  logic            win_ok;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] rsp_valid_q;
  logic [7:0]      rsp_sum_q;
  logic [NREQ-1:0] one;

  assign one = {{(NREQ-1){1'b0}}, 1'b1};

  // first valid port searching upward from last_gnt+1
  always_comb begin
    win    = '0;
    win_ok = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = last_gnt + IW'(k);
      if (!win_ok && bus.req_valid[cand]) begin
        win_ok = 1'b1;
        win    = cand;
      end
    end
  end

  assign bus.req_ready =
    (state == ARB && rst && win_ok) ? (one << win) : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign busy          = (state != ARB);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ARB;
      cnt         <= '0;
      last_gnt    <= IW'(NREQ - 1);
      gnt         <= '0;
      add_en      <= 1'b0;
      add_a       <= '0;
      add_b       <= '0;
      rsp_sum_q   <= '0;
      rsp_valid_q <= '0;
    end else begin
      add_en      <= 1'b0;
      rsp_valid_q <= '0;
      unique case (state)
        ARB: begin
          if (win_ok) begin
            add_a    <= bus.req_a[{win, 3'b000} +: 8];
            add_b    <= bus.req_b[{win, 3'b000} +: 8];
            gnt      <= win;
            last_gnt <= win;
            add_en   <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          if (cnt == CW'(RUN_CYCLES - 1)) begin
            cnt    <= '0;
            add_en <= 1'b1;
            state  <= CAPT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CAPT: begin
          rsp_sum_q   <= add_out;
          rsp_valid_q <= one << gnt;
          state       <= RESP;
        end
        RESP: begin
          state <= ARB;
        end
        default: begin
          state <= ARB;
        end
      endcase
    end
  end

endmodule
